// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - BF16 types, constants, accumulator states and leading-zero helper
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  localparam int          BF16_BIAS = 127;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam logic [15:0] BF16_NINF = 16'hFF80;

  typedef enum logic [1:0] {WAIT_IN, ADD, OUT} accum_state_e;

  // Returns 11 for an all-zero input.
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) lzc11 = 4'(10 - i);
    end
  endfunction

endpackage

// File: rtl/bf16_align.sv
// rtl/bf16_align.sv - combinational align stage: flush, swap, shift with sticky, special flags
module bf16_align
  import bf16_pkg::*;
(
  input  logic [15:0] i_acc,
  input  logic [15:0] i_prod,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [10:0] o_sig_l,
  output logic [10:0] o_sig_s,
  output logic        o_sub,
  output logic        o_nan,
  output logic        o_inf,
  output logic        o_inf_sign
);

  bf16_t       w_a, w_b, w_l, w_s;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [7:0]  w_sig_l, w_sig_s, w_diff;
  logic [18:0] w_wide;

  always_comb begin
    w_a = i_acc;
    w_b = i_prod;
    w_a_nan = (w_a.exp == 8'hFF) && (w_a.man != '0);
    w_b_nan = (w_b.exp == 8'hFF) && (w_b.man != '0);
    w_a_inf = (w_a.exp == 8'hFF) && (w_a.man == '0);
    w_b_inf = (w_b.exp == 8'hFF) && (w_b.man == '0);
    if (w_a.exp == '0) w_a.man = '0;
    if (w_b.exp == '0) w_b.man = '0;

    if ({w_b.exp, w_b.man} > {w_a.exp, w_a.man}) begin
      w_l = w_b;
      w_s = w_a;
    end else begin
      w_l = w_a;
      w_s = w_b;
    end
    w_sig_l = (w_l.exp == '0) ? 8'h00 : {1'b1, w_l.man};
    w_sig_s = (w_s.exp == '0) ? 8'h00 : {1'b1, w_s.man};
    w_diff  = w_l.exp - w_s.exp;

    // Top ten bits of the shifted window are significand+G+R; the rest fold into sticky.
    w_wide  = {w_sig_s, 11'b0} >> w_diff[3:0];
    o_sig_s = (w_diff >= 8'd11) ? {10'b0, |w_sig_s} : {w_wide[18:9], |w_wide[8:0]};
    o_sig_l = {w_sig_l, 3'b000};
    o_sign  = w_l.sign;
    o_exp   = w_l.exp;
    o_sub   = w_a.sign ^ w_b.sign;

    o_nan      = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign));
    o_inf      = w_a_inf || w_b_inf;
    o_inf_sign = w_a_inf ? w_a.sign : w_b.sign;
  end

endmodule

// File: rtl/bf16_accum.sv
// rtl/bf16_accum.sv - streaming BF16 sequence accumulator with add/normalize/round stage and FSM
module bf16_accum
  import bf16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [15:0]      i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [15:0]      o_out_data,
  output logic             o_out_ovf,
  output logic [CNT_W-1:0] o_out_count
);

  accum_state_e     r_state;
  logic [15:0]      r_acc;
  logic             r_ovf, r_last, r_in_ready, r_out_valid;
  logic [CNT_W-1:0] r_count;

  logic             r_sign, r_sub, r_nan, r_inf, r_inf_sign;
  logic [7:0]       r_exp;
  logic [10:0]      r_sig_l, r_sig_s;

  logic             w_sign, w_sub, w_nan, w_inf, w_inf_sign;
  logic [7:0]       w_exp1;
  logic [10:0]      w_sig_l, w_sig_s;

  bf16_align u_align (
    .i_acc      (r_acc),
    .i_prod     (i_in_data),
    .o_sign     (w_sign),
    .o_exp      (w_exp1),
    .o_sig_l    (w_sig_l),
    .o_sig_s    (w_sig_s),
    .o_sub      (w_sub),
    .o_nan      (w_nan),
    .o_inf      (w_inf),
    .o_inf_sign (w_inf_sign)
  );

  logic [11:0]       w_sum;
  logic [10:0]       w_norm;
  logic [3:0]        w_lz;
  logic              w_rnd, w_ovf;
  logic [8:0]        w_mant;
  logic signed [9:0] w_exp_n, w_exp_r;
  logic [15:0]       w_res;

  always_comb begin
    w_sum = r_sub ? ({1'b0, r_sig_l} - {1'b0, r_sig_s}) : ({1'b0, r_sig_l} + {1'b0, r_sig_s});
    w_lz  = lzc11(w_sum[10:0]);
    if (w_sum[11]) begin
      w_norm  = {w_sum[11:2], |w_sum[1:0]};
      w_exp_n = $signed({2'b00, r_exp}) + 10'sd1;
    end else begin
      w_norm  = w_sum[10:0] << w_lz;
      w_exp_n = $signed({2'b00, r_exp}) - $signed({6'b0, w_lz});
    end
    w_rnd   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant  = {1'b0, w_norm[10:3]} + {8'b0, w_rnd};
    w_exp_r = w_mant[8] ? (w_exp_n + 10'sd1) : w_exp_n;

    w_ovf = 1'b0;
    if (r_nan) begin
      w_res = BF16_QNAN;
    end else if (r_inf) begin
      w_res = r_inf_sign ? BF16_NINF : BF16_PINF;
    end else if (w_sum == '0) begin
      // Cancellation yields +0; only a sum of two like-signed zeros keeps the sign.
      w_res = r_sub ? 16'h0000 : {r_sign, 15'b0};
    end else if (w_exp_r >= 10'sd255) begin
      w_res = r_sign ? BF16_NINF : BF16_PINF;
      w_ovf = 1'b1;
    end else if (w_exp_r <= 10'sd0) begin
      w_res = {r_sign, 15'b0};
    end else begin
      w_res = {r_sign, w_exp_r[7:0], w_mant[6:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= WAIT_IN;
      r_acc       <= 16'h0000;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_sig_l     <= '0;
      r_sig_s     <= '0;
      r_sub       <= 1'b0;
      r_nan       <= 1'b0;
      r_inf       <= 1'b0;
      r_inf_sign  <= 1'b0;
    end else begin
      case (r_state)
        WAIT_IN: if (i_in_valid) begin
          r_sign     <= w_sign;
          r_exp      <= w_exp1;
          r_sig_l    <= w_sig_l;
          r_sig_s    <= w_sig_s;
          r_sub      <= w_sub;
          r_nan      <= w_nan;
          r_inf      <= w_inf;
          r_inf_sign <= w_inf_sign;
          r_last     <= i_in_last;
          if (r_count != '1) r_count <= r_count + 1'b1;
          r_in_ready <= 1'b0;
          r_state    <= ADD;
        end
        ADD: begin
          r_acc <= w_res;
          r_ovf <= r_ovf | w_ovf;
          if (r_last) begin
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= WAIT_IN;
          end
        end
        OUT: if (i_out_ready) begin
          r_acc       <= 16'h0000;
          r_ovf       <= 1'b0;
          r_count     <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= WAIT_IN;
        end
        default: r_state <= WAIT_IN;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_acc;
  assign o_out_ovf   = r_ovf;
  assign o_out_count = r_count;

endmodule

// File: tb/tb_bf16_accum.sv
// tb/tb_bf16_accum.sv - directed self-checking bench for bf16_accum
module tb_bf16_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bf16_accum #(.CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_ovf   (out_ovf),
    .o_out_count (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    chk("out_valid_after_accept", 32'(out_valid), 32'd0);
  endtask

  task automatic get_result(input string tag, input logic [15:0] d, input logic ovf,
                            input logic [7:0] cnt);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);

    // 1 + 1 = 2 with exact latency: out_valid rises one cycle after the ADD cycle.
    send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b1);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    get_result("one_plus_one", 16'h4000, 1'b0, 8'd2);

    send(16'h3F80, 1'b0);
    send(16'hBF80, 1'b1);
    get_result("cancel", 16'h0000, 1'b0, 8'd2);
    send(16'h8000, 1'b1);
    get_result("neg_zero", 16'h0000, 1'b0, 8'd1);

    send(16'h3F80, 1'b0);
    send(16'h3B80, 1'b1);
    get_result("tie_even0", 16'h3F80, 1'b0, 8'd2);
    send(16'h3F81, 1'b0);
    send(16'h3B80, 1'b1);
    get_result("tie_odd", 16'h3F82, 1'b0, 8'd2);

    send(16'h7F7F, 1'b0);
    send(16'h7F7F, 1'b1);
    get_result("overflow", 16'h7F80, 1'b1, 8'd2);
    send(16'h4000, 1'b1);
    get_result("ovf_cleared", 16'h4000, 1'b0, 8'd1);

    send(16'h7F80, 1'b0);
    send(16'hFF80, 1'b1);
    get_result("inf_minus_inf", 16'h7FC0, 1'b0, 8'd2);
    send(16'h7FC1, 1'b0);
    send(16'h3F80, 1'b1);
    get_result("nan_sticky", 16'h7FC0, 1'b0, 8'd2);

    // Backpressure with a stray in_valid that must be ignored.
    send(16'h3F80, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'h3F80);
      chk("hold_out_count", 32'(out_count), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    get_result("hold", 16'h3F80, 1'b0, 8'd1);

    // Reset mid-sequence discards the partial sum.
    send(16'h4000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h0);
    send(16'h3F80, 1'b1);
    get_result("after_rst", 16'h3F80, 1'b0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bf16_accum.md
# bf16_accum

Streaming BF16 accumulator that consumes the registered product stream of the systolic array's BF16 multiplier and reduces each sequence of products (delimited by `in_last`) to one BF16 sum. It sits directly downstream of the multiplier inside a processing element. A result is presented on a valid/ready output port. It uses a 2-stage add pipeline: align, then add/normalize/round. Throughput is one product every 2 cycles.

## Interface
- `CNT_W`, default 8: width of the per-sequence product counter. The counter saturates at 2^CNT_W-1.
- `clk`, input, 1: clock. All state updates occur on the rising edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `in_valid`, input, 1: product beat valid.
- `in_ready`, output, 1: accumulator can accept a beat.
- `in_data`, input, 16: BF16 product {sign, exp[7:0], man[6:0]}.
- `in_last`, input, 1: beat is the final product of the sequence.
- `out_valid`, output, 1: sequence sum available.
- `out_ready`, input, 1: consumer accepts the sum.
- `out_data`, output, 16: BF16 sum.
- `out_ovf`, output, 1: a finite-operand add overflowed to infinity during the sequence. Sticky until the output handshake.
- `out_count`, output, CNT_W: number of beats accepted in the sequence.

## Operation
- The FSM has 3 states: WAIT_IN, ADD, OUT.
  - `in_ready` = (state == WAIT_IN). It is a pure state decode and does not depend on `out_ready`.
  - WAIT_IN: on `in_valid & in_ready`, stage 1 is registered, the state goes to ADD and `last_q` <= `in_last`.
  - ADD: stage 2 writes `acc`. The next state is OUT if `last_q`, otherwise WAIT_IN.
  - OUT: `out_valid` = 1 and `out_data` = `acc`. On `out_ready`, `acc` <= +0 (0x0000), `out_ovf` <= 0, `out_count` <= 0, and the state goes to WAIT_IN.
- The accumulator starts every sequence at +0. A single-beat sequence therefore outputs +0 + x.
- Stage 1 (align, registered on the accept edge):
  - Exp = 0 operands are flushed to signed zero.
  - The larger-magnitude operand is selected by comparing {exp, man}.
  - Significands are 8 bits with the implicit 1. The smaller significand is right-shifted by the exponent difference into 8+3 bits (guard, round, sticky). A shift of 11 or more leaves only sticky.
  - Effective subtract = sign_a ^ sign_b.
  - Special-case flags are registered alongside.
- Stage 2 (ADD state):
  - 12-bit add or subtract.
  - Normalize: on a carry-out, right-shift 1 and increment exp. Otherwise left-shift by the leading-zero count.
  - Round to nearest, ties to even, on G/R/S.
  - A rounding carry increments exp and clears the mantissa.
  - Biased exp ≥ 255 gives ±inf (0x7F80/0xFF80) and sets `out_ovf`.
  - Biased exp ≤ 0 flushes to signed zero.
  - An exact-zero result of subtraction is +0. -0 + -0 = -0.
- Special cases, highest priority first:
  - Any NaN operand gives 0x7FC0.
  - inf + opposite-signed inf gives 0x7FC0.
  - Any inf gives that inf.
  - Once `acc` is NaN it stays 0x7FC0 until the output handshake.
- `out_count` increments on each accepted beat and saturates.

## Timing
- Reset values: state WAIT_IN, `acc` 0x0000, `in_ready` 1, `out_valid` 0, `out_data` 0x0000, `out_ovf` 0, `out_count` 0. All pipeline registers are cleared.
- Latency: a last beat accepted at edge k gives `acc` written at edge k+1. `out_valid` is high in the cycle after edge k+1.
- After a non-last beat accepted at edge k, `in_ready` = 0 in cycle k+1 and 1 again after edge k+1.
- While in OUT, `out_data`, `out_ovf` and `out_count` are held stable for any number of `out_ready`-low cycles. `in_ready` stays 0.
- The output handshake at edge m gives `in_ready` = 1 in the cycle after m. There is no same-cycle input accept.
- `rst` asserted in any state wins at the next edge: the in-flight beat and the partial sum are discarded.
- `in_valid` without `in_ready` is ignored. The upstream side holds its data, per the standard valid/ready rule.

## Structure
- Package `bf16_pkg` contains:
  - typedef `bf16_t` (packed struct: sign, exp[7:0], man[6:0]);
  - constants `BF16_BIAS` = 127, `BF16_QNAN` = 16'h7FC0, `BF16_PINF` = 16'h7F80, `BF16_NINF` = 16'hFF80;
  - enum `accum_state_e` {WAIT_IN, ADD, OUT}.
- One sub-module, `bf16_align`: combinational stage 1 (flush, swap, shift with sticky, special flags). Stage 2, the FSM and the counters stay in `bf16_accum`.

## Test plan
- 0x3F80, then 0x3F80 with last: `out_data` 0x4000, `out_count` 2. `out_valid` rises 2 cycles after the last accept. `in_ready` is low the cycle after each accept.
- 0x3F80 + 0xBF80 with last: 0x0000 (+0). A single beat of 0x8000 with last: 0x0000.
- 0x3F80 + 0x3B80: tie, result 0x3F80. 0x3F81 + 0x3B80: tie rounds to even, result 0x3F82.
- 0x7F7F + 0x7F7F: 0x7F80 with `out_ovf` 1. Next sequence 0x4000 alone: 0x4000 with `out_ovf` 0.
- 0x7F80 + 0xFF80: 0x7FC0. Sequence 0x7FC1, then 0x3F80: 0x7FC0.
- Hold `out_ready` low 5 cycles: outputs stable, `in_ready` 0. Assert `rst` mid-sequence after 0x4000: the following 0x3F80 with last gives 0x3F80 and `out_count` 1.
